multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mips_ctrl_pkg.sv | 55 +++++
 rtl/mc_output_decode.sv | 66 ++++++
 rtl/multicycle_control.sv | 91 +++++++++
 tb/tb_multicycle_control.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller.
// States, opcodes, ALU/mux select codes and the control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // fetch_strobe marks FETCH; pc_write/ir_write there are qualified
  // by mem_ready in the top, everything else is pure Moore.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       fetch_strobe;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// State-to-control-word decode for the multicycle controller.
// Purely combinational; unused state codes give an all-zero word.
import mips_ctrl_pkg::*;

module mc_output_decode (
  input  logic [3:0] i_state,
  output ctrl_t      o_ctrl
);

  // Moore control word per state, zero unless listed
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read     = 1'b1;
        o_ctrl.fetch_strobe = 1'b1;
        o_ctrl.alu_src_b    = SRCB_FOUR;
        o_ctrl.alu_op       = ALU_ADD;
        o_ctrl.pc_source    = PCSRC_ALU;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = SRCB_IMM_SH;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
        o_ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_REG;
        o_ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = SRCB_REG;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main controller: state register, next-state
// logic and sticky illegal-opcode flag; outputs via mc_output_decode.
import mips_ctrl_pkg::*;

module multicycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op
);

  logic [3:0] r_state;
  logic       r_illegal;
  ctrl_t      w_ctrl;
  logic       w_fetch_go;

  mc_output_decode u_dec (
    .i_state (r_state),
    .o_ctrl  (w_ctrl)
  );

  // ready is masked by rst_n so the fetch strobes stay low in reset
  assign w_fetch_go    = w_ctrl.fetch_strobe & mem_ready & rst_n;
  assign pc_write      = w_ctrl.pc_write | w_fetch_go;
  assign ir_write      = w_fetch_go;
  assign pc_write_cond = w_ctrl.pc_write_cond;
  assign i_or_d        = w_ctrl.i_or_d;
  assign mem_read      = w_ctrl.mem_read;
  assign mem_write     = w_ctrl.mem_write;
  assign mem_to_reg    = w_ctrl.mem_to_reg;
  assign reg_dst       = w_ctrl.reg_dst;
  assign reg_write     = w_ctrl.reg_write;
  assign alu_src_a     = w_ctrl.alu_src_a;
  assign alu_src_b     = w_ctrl.alu_src_b;
  assign alu_op        = w_ctrl.alu_op;
  assign pc_source     = w_ctrl.pc_source;
  assign state         = r_state;
  assign illegal_op    = r_illegal;

  // state sequencing; bad opcodes fall back to FETCH and latch the flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:
          if (mem_ready) r_state <= S_DECODE;
        S_DECODE:
          case (opcode)
            OP_LW, OP_SW: r_state <= S_MEM_ADDR;
            OP_RTYPE:     r_state <= S_EXECUTE;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            default: begin
              r_state   <= S_FETCH;
              r_illegal <= 1'b1;
            end
          endcase
        S_MEM_ADDR:
          r_state <= (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:
          if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WRITE:
          if (mem_ready) r_state <= S_FETCH;
        S_EXECUTE: r_state <= S_R_WB;
        S_MEM_WB,
        S_R_WB,
        S_BRANCH,
        S_JUMP:    r_state <= S_FETCH;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control.
// Expected words are queued as stimulus is driven, then popped.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b000000;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write;
  logic       mem_to_reg, ir_write, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       illegal_op;

  int n_run = 0;
  int n_fail = 0;
  logic g_ill = 1'b0;
  logic [20:0] sb[$];

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .ir_write(ir_write), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic logic [20:0] obs();
    return {illegal_op, state, pc_write, pc_write_cond, i_or_d,
            mem_read, mem_write, mem_to_reg, ir_write, reg_dst,
            reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  // reference control table written from the state descriptions
  function automatic logic [20:0] exp_word(input logic [3:0] s,
                                           input logic rdy,
                                           input logic ill);
    logic pw, pwc, iod, mr, mw, m2r, irw, rd, rw, sa;
    logic [1:0] srcb, ao, ps;
    {pw, pwc, iod, mr, mw, m2r, irw, rd, rw, sa} = '0;
    srcb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (s)
      4'd0: begin mr = 1; srcb = 2'b01; pw = rdy; irw = rdy; end
      4'd1: srcb = 2'b11;
      4'd2: begin sa = 1; srcb = 2'b10; end
      4'd3: begin mr = 1; iod = 1; end
      4'd4: begin rw = 1; m2r = 1; end
      4'd5: begin mw = 1; iod = 1; end
      4'd6: begin sa = 1; ao = 2'b10; end
      4'd7: begin rw = 1; rd = 1; end
      4'd8: begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      4'd9: begin pw = 1; ps = 2'b10; end
      default: ;
    endcase
    return {ill, s, pw, pwc, iod, mr, mw, m2r, irw, rd, rw, sa,
            srcb, ao, ps};
  endfunction

  // drive one cycle and queue what the outputs must show in it
  task automatic cyc(input logic [3:0] s, input logic rdy,
                     input logic ill);
    @(negedge clk);
    mem_ready = rdy;
    sb.push_back(exp_word(s, rdy, ill));
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    mem_ready = 1'b1;
    #1;
    e = exp_word(4'd0, 1'b0, 1'b0);
    n_run++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reset_hold: got %h want %h", obs(), e);
    end
    mem_ready = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    logic [3:0] st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
    logic rd [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [20:0] e;
    opcode = 6'b000000;
    for (int i = 0; i < 5; i++) begin
      cyc(st[i], rd[i], g_ill);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL rtype step %0d: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_lw_wait();
    logic [3:0] st [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3,
                           4'd4, 4'd0};
    logic rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [20:0] e;
    opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      cyc(st[i], rd[i], g_ill);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL lw_wait step %0d: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_sw_beq();
    logic [3:0] st [9] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0,
                           4'd0, 4'd1, 4'd8, 4'd0};
    logic rd [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                     1'b1, 1'b1, 1'b1, 1'b0};
    logic [20:0] e;
    for (int i = 0; i < 9; i++) begin
      opcode = (i < 5) ? 6'b101011 : 6'b000100;
      cyc(st[i], rd[i], g_ill);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL sw_beq step %0d: got %h want %h", i, obs(), e);
      end
    end
  endtask

  task automatic test_j_illegal();
    logic [3:0] st [8] = '{4'd0, 4'd1, 4'd9, 4'd0,
                           4'd0, 4'd1, 4'd0, 4'd0};
    logic rd [8] = '{1'b1, 1'b1, 1'b1, 1'b0,
                     1'b1, 1'b1, 1'b0, 1'b0};
    logic il [8] = '{1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b0, 1'b1, 1'b1};
    logic [20:0] e;
    for (int i = 0; i < 8; i++) begin
      opcode = (i < 4) ? 6'b000010 : 6'b111111;
      cyc(st[i], rd[i], il[i]);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL j_illegal step %0d: got %h want %h",
                 i, obs(), e);
      end
    end
    g_ill = 1'b1;
  endtask

  task automatic test_unused_state();
    logic [20:0] e;
    @(negedge clk);
    mem_ready = 1'b0;
    force dut.r_state = 4'd12;
    #1 release dut.r_state;
    #1;
    sb.push_back(exp_word(4'd12, 1'b0, g_ill));
    e = sb.pop_front();
    n_run++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL unused_hold: got %h want %h", obs(), e);
    end
    cyc(4'd0, 1'b0, g_ill);
    e = sb.pop_front();
    n_run++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL unused_exit: got %h want %h", obs(), e);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] st [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    logic rd [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [20:0] e;
    opcode = 6'b100011;
    for (int i = 0; i < 4; i++) begin
      cyc(st[i], rd[i], g_ill);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL rst_mid step %0d: got %h want %h", i, obs(), e);
      end
    end
    mem_ready = 1'b1;
    #2 rst_n = 1'b0;
    g_ill = 1'b0;
    #1;
    e = exp_word(4'd0, 1'b0, 1'b0);
    n_run++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL rst_async: got %h want %h", obs(), e);
    end
    mem_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(4'd0, 1'b0, g_ill);
      e = sb.pop_front();
      n_run++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL rst_after step %0d: got %h want %h",
                 i, obs(), e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw_beq();
    test_j_illegal();
    test_unused_state();
    test_reset_mid();
    test_rtype();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
